// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for the ID stage: opcode-driven format decode, XLEN extension,
// PC-relative target, and a small result FIFO behind a valid/ready handshake.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // A one-entry FIFO still needs a one-bit pointer; it simply never leaves zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        T_I    = 3'd0,
        T_S    = 3'd1,
        T_B    = 3'd2,
        T_U    = 3'd3,
        T_J    = 3'd4,
        T_Z    = 3'd5,
        T_NONE = 3'd7
    } imm_type_e;

    logic [6:0]      opcode;
    logic            sgn;
    logic [31:0]     imm32;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] dec_target;

    assign opcode = in_instr[6:0];
    assign sgn    = in_instr[31];

    always_comb begin
        imm32       = '0;
        dec_type    = T_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_type = T_I;
                imm32    = {{20{sgn}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_type = T_S;
                imm32    = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_type = T_B;
                imm32    = {{20{sgn}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = T_U;
                imm32    = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_type = T_J;
                imm32    = {{12{sgn}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                if (in_instr[14]) begin
                    dec_type = T_Z;
                    imm32    = {27'b0, in_instr[19:15]};
                end
            end
            7'b0110011, 7'b0001111: begin
                dec_type = T_NONE;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Every format is sign-extended from bit 31; zimm has bit 31 clear so it comes out zero-extended.
    generate
        if (XLEN > 32) begin : g_ext_wide
            assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_ext_narrow
            assign imm_ext = imm32[XLEN-1:0];
        end
    endgenerate

    assign dec_target = in_pc + imm_ext;

    logic [XLEN-1:0] mem_imm    [DEPTH];
    logic [XLEN-1:0] mem_target [DEPTH];
    logic [2:0]      mem_type   [DEPTH];
    logic            mem_illegal[DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i]     <= '0;
                mem_target[i]  <= '0;
                mem_type[i]    <= T_NONE;
                mem_illegal[i] <= 1'b0;
            end
        end else if (push) begin
            mem_imm[wr_ptr]     <= imm_ext;
            mem_target[wr_ptr]  <= dec_target;
            mem_type[wr_ptr]    <= dec_type;
            mem_illegal[wr_ptr] <= dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Head entry drives the outputs even when empty, so they never go X.
    assign out_imm     = mem_imm[rd_ptr];
    assign out_target  = mem_target[rd_ptr];
    assign out_type    = mem_type[rd_ptr];
    assign out_illegal = mem_illegal[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: 32-bit DEPTH=2 instance plus a 64-bit instance for extension.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [31:0] out_target;
    logic        out_illegal;

    logic        d64_in_valid;
    logic        d64_in_ready;
    logic [31:0] d64_in_instr;
    logic [63:0] d64_in_pc;
    logic        d64_out_valid;
    logic [63:0] d64_out_imm;
    logic [2:0]  d64_out_type;
    logic [63:0] d64_out_target;
    logic        d64_out_illegal;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_type(out_type), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(d64_in_valid), .in_ready(d64_in_ready), .in_instr(d64_in_instr), .in_pc(d64_in_pc),
        .out_valid(d64_out_valid), .out_ready(1'b0), .out_imm(d64_out_imm),
        .out_type(d64_out_type), .out_target(d64_out_target), .out_illegal(d64_out_illegal)
    );

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [31:0] tgt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] sx;
        sx    = {32{i[31]}};
        e.imm = 32'h0;
        e.typ = 3'd7;
        e.ill = 1'b0;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin e.typ = 3'd0; e.imm = $signed(i) >>> 20; end
            7'h23: begin e.typ = 3'd1; e.imm = {sx[31:12], i[31:25], i[11:7]}; end
            7'h63: begin e.typ = 3'd2; e.imm = {sx[31:13], i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin e.typ = 3'd3; e.imm = {i[31:12], 12'h000}; end
            7'h6F: begin e.typ = 3'd4; e.imm = {sx[31:21], i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h73: if (i[14]) begin e.typ = 3'd5; e.imm = {27'h0, i[19:15]}; end
            7'h33, 7'h0F: e.typ = 3'd7;
            default: e.ill = 1'b1;
        endcase
        e.tgt = pc + e.imm;
        return e;
    endfunction

    // Called at a negedge with inputs already set; accounts for the handshakes of the coming edge.
    task automatic cycle();
        exp_t e;
        chk("out_valid", out_valid, sb.size() != 0);
        chk("in_ready", in_ready, sb.size() < 2);
        if (out_valid && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            popped++;
            chk("imm", out_imm, e.imm);
            chk("type", out_type, e.typ);
            chk("target", out_target, e.tgt);
            chk("illegal", out_illegal, e.ill);
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
        @(negedge clk);
    endtask

    logic [31:0] dir_instr [5] = '{32'hFFF00093, 32'hFE000CE3, 32'h340FD073, 32'h020000EF, 32'h0000007F};
    logic [31:0] dir_pc    [5] = '{32'h100, 32'h20, 32'h0, 32'hFFFFFFF0, 32'h40};
    logic [31:0] dir_imm   [5] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'h1F, 32'h20, 32'h0};
    logic [2:0]  dir_type  [5] = '{3'd0, 3'd2, 3'd5, 3'd4, 3'd7};
    logic [31:0] dir_tgt   [5] = '{32'hFF, 32'h18, 32'h0 + 32'h1F, 32'h10, 32'h40};
    logic        dir_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0]  ops       [13] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
                                    7'h6F, 7'h73, 7'h33, 7'h0F, 7'h7F, 7'h12};

    initial begin
        int start_pop;
        rst          = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_instr     = 32'h0;
        in_pc        = 32'h0;
        out_ready    = 1'b0;
        d64_in_valid = 1'b0;
        d64_in_instr = 32'h0;
        d64_in_pc    = 64'h0;
        #12 rst = 1'b0;
        @(negedge clk);

        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_type", out_type, 7);
        chk("rst_target", out_target, 0);
        chk("rst_illegal", out_illegal, 0);

        // Directed vectors: check the head against hand-derived constants, then pop via scoreboard.
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_instr = dir_instr[k]; in_pc = dir_pc[k];
            cycle();
            in_valid = 1'b0;
            chk("dir_latency", out_valid, 1);
            chk("dir_imm", out_imm, dir_imm[k]);
            chk("dir_type", out_type, dir_type[k]);
            chk("dir_target", out_target, dir_tgt[k]);
            chk("dir_illegal", out_illegal, dir_ill[k]);
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end

        // XLEN=64 lui sign extension
        d64_in_valid = 1'b1; d64_in_instr = 32'h800000B7; d64_in_pc = 64'h0;
        @(negedge clk);
        d64_in_valid = 1'b0;
        chk("x64_valid", d64_out_valid, 1);
        chk("x64_imm", d64_out_imm, 64'hFFFFFFFF80000000);
        chk("x64_type", d64_out_type, 3);
        chk("x64_target", d64_out_target, 64'hFFFFFFFF80000000);

        // Backpressure: three offered, two accepted, head holds entry 0.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = 32'h00100013 + (k << 20); in_pc = 32'h1000 + k * 4;
            chk("bp_ready", in_ready, k < 2);
            cycle();
            chk("bp_hold_imm", out_imm, 32'h1);
            chk("bp_hold_target", out_target, 32'h1001);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_drained", out_valid, 0);
        chk("bp_pops", popped, 7);

        // Streaming with random instructions
        start_pop = popped;
        in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_instr = ($urandom() & 32'hFFFFFF80) | {25'h0, ops[$urandom_range(0, 12)]};
            in_pc    = $urandom();
            if (k > 0) chk("st_valid", out_valid, 1);
            chk("st_ready", in_ready, 1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("st_count", popped - start_pop, 16);

        // Flush with two buffered and a concurrent push
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00500093; in_pc = 32'h10; cycle();
        in_instr = 32'h00600093; in_pc = 32'h14; cycle();
        in_instr = 32'h00700093; in_pc = 32'h18; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("fl_nothing", popped - start_pop, 16);

        // Asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; in_pc = 32'h100; cycle();
        in_instr = 32'h800000B7; in_pc = 32'h200; cycle();
        in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_imm", out_imm, 0);
        chk("ar_type", out_type, 7);
        chk("ar_target", out_target, 0);
        chk("ar_illegal", out_illegal, 0);
        chk("ar_x64_valid", d64_out_valid, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("ar_ready", in_ready, 1);
        out_ready = 1'b1;
        cycle();

        for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
        chk("final_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
